// File: rtl/tlut_operand_loader.sv
// ---------------------------------------------------------------------------
// tlut_operand_loader
//
// Collects a DIM x DIM input tile and then a DIM x DIM weight tile from a
// single valid/ready element stream. Once both tiles are complete, it holds
// them stable and raises enable to the SIMD cell for COMPUTE_CYCLES cycles.
// It then pulses done for one cycle and returns to loading the next tile.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   flush       in   synchronous abort of the current tile (tile regs kept)
//   in_valid    in   upstream element beat valid
//   in_data     in   element value, unsigned, DATA_WIDTH bits
//   in_ready    out  loader accepts a beat this cycle
//   input_bin   out  packed input tile, slot k = k-th input beat
//   weight_bin  out  packed weight tile, slot k = k-th weight beat
//   enable      out  compute enable, high COMPUTE_CYCLES cycles per tile
//   done        out  one-cycle pulse after the last enable cycle
//   busy        out  high unless idle in LOAD_IN with no beats collected
// ---------------------------------------------------------------------------
module tlut_operand_loader #(
    parameter int DIM            = 3,
    parameter int DATA_WIDTH     = 4,
    parameter int COMPUTE_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    input  logic [DATA_WIDTH-1:0]                in_data,
    output logic                                 in_ready,
    output logic [DIM*DIM-1:0][DATA_WIDTH-1:0]   input_bin,
    output logic [DIM*DIM-1:0][DATA_WIDTH-1:0]   weight_bin,
    output logic                                 enable,
    output logic                                 done,
    output logic                                 busy
);

    localparam int NELEM = DIM * DIM;
    localparam int BW    = (NELEM > 1) ? $clog2(NELEM) : 1;

    localparam logic [1:0] S_LOAD_IN = 2'd0;
    localparam logic [1:0] S_LOAD_WT = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [BW-1:0] BEAT_LAST = BW'(NELEM - 1);
    localparam logic [7:0]    CYC_LAST  = 8'(COMPUTE_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] beat_q,  beat_d;
    logic [7:0]    cyc_q,   cyc_d;
    logic          wr_in, wr_wt;

    logic          in_ready_q, enable_q, done_q, busy_q;
    logic [NELEM-1:0][DATA_WIDTH-1:0] input_q, weight_q;

    // in_ready is a registered copy of "state is a load state", so testing
    // in_valid alone inside the load states is equivalent to in_valid && in_ready.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cyc_d   = cyc_q;
        wr_in   = 1'b0;
        wr_wt   = 1'b0;
        if (flush) begin
            // Flush wins over a simultaneous beat: nothing is written.
            state_d = S_LOAD_IN;
            beat_d  = '0;
            cyc_d   = '0;
        end else begin
            case (state_q)
                S_LOAD_IN: begin
                    if (in_valid) begin
                        wr_in = 1'b1;
                        if (beat_q == BEAT_LAST) begin
                            beat_d  = '0;
                            state_d = S_LOAD_WT;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                S_LOAD_WT: begin
                    if (in_valid) begin
                        wr_wt = 1'b1;
                        if (beat_q == BEAT_LAST) begin
                            beat_d  = '0;
                            cyc_d   = '0;
                            state_d = S_COMPUTE;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_LOAD_IN;
                end
                default: begin
                    state_d = S_LOAD_IN;
                    beat_d  = '0;
                    cyc_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from next state so they are plain flops aligned
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD_IN;
            beat_q     <= '0;
            cyc_q      <= '0;
            in_ready_q <= 1'b1;
            enable_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            input_q    <= '0;
            weight_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cyc_q      <= cyc_d;
            in_ready_q <= (state_d == S_LOAD_IN) || (state_d == S_LOAD_WT);
            enable_q   <= (state_d == S_COMPUTE);
            done_q     <= (state_d == S_DONE);
            busy_q     <= (state_d != S_LOAD_IN) || (beat_d != '0);
            if (wr_in) begin
                input_q[beat_q] <= in_data;
            end
            if (wr_wt) begin
                weight_q[beat_q] <= in_data;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign enable     = enable_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign input_bin  = input_q;
    assign weight_bin = weight_q;

endmodule

// File: tb/tb_tlut_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_tlut_operand_loader
//
// Directed bench for tlut_operand_loader. A tile-level model (beats collected
// so far, enable cycles left, done pending) predicts every output each cycle.
// Hand-computed literal expectations at key cycles pin that model down.
// A second instance with COMPUTE_CYCLES = 1 shares the stimulus. It is only
// inspected right after reset, in the back-to-back load sequence.
// ---------------------------------------------------------------------------
module tb_tlut_operand_loader;

    localparam int DIM = 3;
    localparam int DW  = 4;
    localparam int CC  = 16;
    localparam int NE  = DIM * DIM;

    // Tile holding k in slot k, for k = 0..8.
    localparam logic [NE*DW-1:0] TILE_K = 36'h876543210;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic in_ready, enable, done, busy;
    logic [NE-1:0][DW-1:0] in_bin, wt_bin;

    logic in_ready1, enable1, done1, busy1;
    logic [NE-1:0][DW-1:0] in_bin1, wt_bin1;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    tlut_operand_loader #(.DIM(DIM), .DATA_WIDTH(DW), .COMPUTE_CYCLES(CC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .input_bin(in_bin),
        .weight_bin(wt_bin), .enable(enable), .done(done), .busy(busy)
    );

    tlut_operand_loader #(.DIM(DIM), .DATA_WIDTH(DW), .COMPUTE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready1), .input_bin(in_bin1),
        .weight_bin(wt_bin1), .enable(enable1), .done(done1), .busy(busy1)
    );

    // ---------------- behavioural model ----------------
    int m_loaded;   // beats accepted in the current tile, 0..2*NE-1
    int m_left;     // enable cycles still to come
    logic m_done;   // done pulse showing this cycle
    logic [NE-1:0][DW-1:0] m_in, m_wt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loaded <= 0;
            m_left   <= 0;
            m_done   <= 1'b0;
            m_in     <= '0;
            m_wt     <= '0;
        end else if (flush) begin
            m_loaded <= 0;
            m_left   <= 0;
            m_done   <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
        end else if (in_valid) begin
            if (m_loaded < NE) m_in[m_loaded] <= in_data;
            else               m_wt[m_loaded - NE] <= in_data;
            if (m_loaded == 2 * NE - 1) begin
                m_loaded <= 0;
                m_left   <= CC;
            end else begin
                m_loaded <= m_loaded + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            logic e_ready, e_busy;
            e_ready = (m_left == 0) && !m_done;
            e_busy  = !(e_ready && (m_loaded == 0));
            checks = checks + 6;
            if (in_ready !== e_ready) begin
                errors++;
                $display("FAIL cmp_in_ready t=%0t got %b want %b", $time, in_ready, e_ready);
            end
            if (enable !== (m_left > 0)) begin
                errors++;
                $display("FAIL cmp_enable t=%0t got %b want %b", $time, enable, (m_left > 0));
            end
            if (done !== m_done) begin
                errors++;
                $display("FAIL cmp_done t=%0t got %b want %b", $time, done, m_done);
            end
            if (busy !== e_busy) begin
                errors++;
                $display("FAIL cmp_busy t=%0t got %b want %b", $time, busy, e_busy);
            end
            if (in_bin !== m_in) begin
                errors++;
                $display("FAIL cmp_input_bin t=%0t got %h want %h", $time, in_bin, m_in);
            end
            if (wt_bin !== m_wt) begin
                errors++;
                $display("FAIL cmp_weight_bin t=%0t got %h want %h", $time, wt_bin, m_wt);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then land 1 time unit after the next edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    // 18 beats 0..8,0..8 back-to-back, starting in the first cycle after reset.
    task automatic b2b_run(input string tag);
        for (int k = 0; k < 2 * NE; k++) cycle(1'b1, DW'(k % NE), 1'b0);
        // cycle 19
        chk({tag, "_ready_c19"}, 64'(in_ready), 64'd0);
        chk({tag, "_en_c19"}, 64'(enable), 64'd1);
        chk({tag, "_inbin"}, 64'(in_bin), 64'(TILE_K));
        chk({tag, "_wtbin"}, 64'(wt_bin), 64'(TILE_K));
        chk({tag, "_cc1_en_c19"}, 64'(enable1), 64'd1);
        chk({tag, "_cc1_done_c19"}, 64'(done1), 64'd0);
        cycle(1'b0, '0, 1'b0);
        // cycle 20
        chk({tag, "_cc1_en_c20"}, 64'(enable1), 64'd0);
        chk({tag, "_cc1_done_c20"}, 64'(done1), 64'd1);
        cycle(1'b0, '0, 1'b0);
        // cycle 21
        chk({tag, "_cc1_done_c21"}, 64'(done1), 64'd0);
        chk({tag, "_cc1_ready_c21"}, 64'(in_ready1), 64'd1);
        for (int i = 0; i < 13; i++) cycle(1'b0, '0, 1'b0);
        // cycle 34
        chk({tag, "_en_c34"}, 64'(enable), 64'd1);
        chk({tag, "_done_c34"}, 64'(done), 64'd0);
        cycle(1'b0, '0, 1'b0);
        // cycle 35
        chk({tag, "_en_c35"}, 64'(enable), 64'd0);
        chk({tag, "_done_c35"}, 64'(done), 64'd1);
        chk({tag, "_ready_c35"}, 64'(in_ready), 64'd0);
        cycle(1'b0, '0, 1'b0);
        // cycle 36
        chk({tag, "_done_c36"}, 64'(done), 64'd0);
        chk({tag, "_ready_c36"}, 64'(in_ready), 64'd1);
        chk({tag, "_busy_c36"}, 64'(busy), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_inbin", 64'(in_bin), 64'd0);
        chk("rst_wtbin", 64'(wt_bin), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(in_ready), 64'd1);

        // back-to-back load
        b2b_run("b2b");

        // bubbled load; bubble cycles carry junk data that must be ignored
        for (int i = 0; i < 4 * NE; i++) begin
            if (i == 4 * NE - 1) chk("bub_en_before_last", 64'(enable), 64'd0);
            if (i % 2 == 1) cycle(1'b1, DW'((i / 2) % NE), 1'b0);
            else            cycle(1'b0, 4'hF, 1'b0);
        end
        chk("bub_en_after_last", 64'(enable), 64'd1);
        chk("bub_inbin", 64'(in_bin), 64'(TILE_K));
        chk("bub_wtbin", 64'(wt_bin), 64'(TILE_K));
        for (int i = 0; i < CC + 2; i++) cycle(1'b0, '0, 1'b0);

        // flush mid-load together with input beat 5
        for (int k = 0; k < 5; k++) cycle(1'b1, DW'(10 + k), 1'b0);
        chk("fl_slot4", 64'(in_bin[4]), 64'hE);
        cycle(1'b1, 4'h1, 1'b1);
        chk("fl_slot5_kept", 64'(in_bin[5]), 64'h5);
        chk("fl_busy", 64'(busy), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        cycle(1'b1, 4'h3, 1'b0);
        chk("fl_next_slot0", 64'(in_bin[0]), 64'h3);
        chk("fl_slot1_kept", 64'(in_bin[1]), 64'hB);
        for (int k = 1; k < NE; k++) cycle(1'b1, DW'(k + 6), 1'b0);
        for (int k = 0; k < NE; k++) cycle(1'b1, DW'(15 - k), 1'b0);
        chk("fl_tile_in", 64'(in_bin), 64'h edcba9873);
        chk("fl_tile_wt", 64'(wt_bin), 64'h789abcdef);

        // flush in the 4th enable cycle
        chk("fc_en1", 64'(enable), 64'd1);
        repeat (3) cycle(1'b0, '0, 1'b0);
        chk("fc_en4", 64'(enable), 64'd1);
        cycle(1'b0, '0, 1'b1);
        chk("fc_en_off", 64'(enable), 64'd0);
        chk("fc_no_done", 64'(done), 64'd0);
        chk("fc_ready", 64'(in_ready), 64'd1);
        repeat (CC) cycle(1'b0, '0, 1'b0);

        // reset in the 8th enable cycle
        for (int k = 0; k < 2 * NE; k++) cycle(1'b1, DW'((k * 7) % 16), 1'b0);
        repeat (7) cycle(1'b0, '0, 1'b0);
        chk("rc_en8", 64'(enable), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rc_enable", 64'(enable), 64'd0);
        chk("rc_done", 64'(done), 64'd0);
        chk("rc_inbin", 64'(in_bin), 64'd0);
        chk("rc_wtbin", 64'(wt_bin), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b2b_run("rst_b2b");

        repeat (3) cycle(1'b0, '0, 1'b0);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
